// File: rtl/enigma_pkg.sv
// Shared letter/position types, alphabet constants and the controller state encoding.
// Position helpers keep every rotor position inside 0..25 without relying on 5-bit wrap.
package enigma_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0] letter_t;

  localparam letter_t NUM_LETTERS    = 5'(LETTERS);
  localparam letter_t LAST_POS       = 5'(LETTERS - 1);
  localparam letter_t LETTER_INVALID = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    DRIVE,
    WAIT,
    HOLD
  } ctrl_state_t;

  function automatic letter_t pos_inc(input letter_t p);
    return (p == LAST_POS) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic letter_t pos_sanitize(input letter_t p);
    return (p >= NUM_LETTERS) ? 5'd0 : p;
  endfunction

endpackage

// File: rtl/rotor_step_ctrl_if.sv
// Bundles the front-end letter handshake, position load and rotor-chain signals of the step controller.
// master = controller side, slave = front end plus rotor stack.
interface rotor_step_ctrl_if;
  import enigma_pkg::*;

  logic    load;
  letter_t load_pos1;
  letter_t load_pos2;
  letter_t load_pos3;
  logic    in_valid;
  logic    in_ready;
  letter_t in_letter;
  letter_t pos1;
  letter_t pos2;
  letter_t pos3;
  letter_t rotor_data;
  letter_t rotor_result;
  logic    rotor_done;
  logic    out_valid;
  logic    out_ready;
  letter_t out_letter;

  modport master (
    input  load, load_pos1, load_pos2, load_pos3,
    input  in_valid, in_letter,
    output in_ready,
    output pos1, pos2, pos3, rotor_data,
    input  rotor_result, rotor_done,
    output out_valid, out_letter,
    input  out_ready
  );

  modport slave (
    output load, load_pos1, load_pos2, load_pos3,
    output in_valid, in_letter,
    input  in_ready,
    input  pos1, pos2, pos3, rotor_data,
    output rotor_result, rotor_done,
    input  out_valid, out_letter,
    output out_ready
  );

endinterface

// File: rtl/rotor_odometer.sv
// Combinational Enigma stepping: fast rotor always advances, middle/slow rotors follow the notches.
// Zero latency; no handshake.
module rotor_odometer
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = 5'd16,
  parameter letter_t NOTCH2 = 5'd4
) (
  input  letter_t i_pos1,
  input  letter_t i_pos2,
  input  letter_t i_pos3,
  output letter_t o_pos1,
  output letter_t o_pos2,
  output letter_t o_pos3
);

  logic w_slow_step;
  logic w_mid_step;

  // Middle rotor sitting on its own notch moves again next press: the double-step.
  assign w_slow_step = (i_pos2 == NOTCH2);
  assign w_mid_step  = (i_pos1 == NOTCH1) | w_slow_step;

  assign o_pos1 = pos_inc(i_pos1);
  assign o_pos2 = w_mid_step  ? pos_inc(i_pos2) : i_pos2;
  assign o_pos3 = w_slow_step ? pos_inc(i_pos3) : i_pos3;

endmodule

// File: rtl/rotor_step_ctrl.sv
// Steps rotor positions, drives one letter through the rotor chain, returns the result; accept-to-out_valid >= 4 cycles.
// One letter in flight: in_ready only in IDLE, result held until out_ready. ROTOR_TIMEOUT_EN adds a WAIT abort.
module rotor_step_ctrl
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = 5'd16,
  parameter letter_t NOTCH2 = 5'd4
`ifdef ROTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               rst,
  rotor_step_ctrl_if.master  bus
);

  ctrl_state_t r_state;
  letter_t     r_pos1;
  letter_t     r_pos2;
  letter_t     r_pos3;
  letter_t     r_letter;
  letter_t     r_rotor_data;
  letter_t     r_out_letter;
  logic        r_out_valid;

  letter_t     w_nxt1;
  letter_t     w_nxt2;
  letter_t     w_nxt3;

`ifdef ROTOR_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  rotor_odometer #(
    .NOTCH1 (NOTCH1),
    .NOTCH2 (NOTCH2)
  ) u_odometer (
    .i_pos1 (r_pos1),
    .i_pos2 (r_pos2),
    .i_pos3 (r_pos3),
    .o_pos1 (w_nxt1),
    .o_pos2 (w_nxt2),
    .o_pos3 (w_nxt3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pos1       <= 5'd0;
      r_pos2       <= 5'd0;
      r_pos3       <= 5'd0;
      r_letter     <= 5'd0;
      r_rotor_data <= 5'd0;
      r_out_letter <= 5'd0;
      r_out_valid  <= 1'b0;
`ifdef ROTOR_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // Load has priority; in_ready is low whenever load is high.
          if (bus.load) begin
            r_pos1 <= pos_sanitize(bus.load_pos1);
            r_pos2 <= pos_sanitize(bus.load_pos2);
            r_pos3 <= pos_sanitize(bus.load_pos3);
          end else if (bus.in_valid) begin
            r_letter <= bus.in_letter;
            if (bus.in_letter >= NUM_LETTERS) begin
              r_out_letter <= bus.in_letter;
              r_out_valid  <= 1'b1;
              r_state      <= HOLD;
            end else begin
              r_state <= STEP;
            end
          end
        end

        STEP: begin
          r_pos1  <= w_nxt1;
          r_pos2  <= w_nxt2;
          r_pos3  <= w_nxt3;
          r_state <= DRIVE;
        end

        DRIVE: begin
          r_rotor_data <= r_letter;
`ifdef ROTOR_TIMEOUT_EN
          r_wait_cnt   <= '0;
`endif
          r_state      <= WAIT;
        end

        WAIT: begin
          // A done seen during DRIVE belongs to the previous letter and is never sampled.
          if (bus.rotor_done) begin
            r_out_letter <= bus.rotor_result;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end
`ifdef ROTOR_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_out_letter <= LETTER_INVALID;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end

        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == IDLE) & ~bus.load;
  assign bus.pos1       = r_pos1;
  assign bus.pos2       = r_pos2;
  assign bus.pos3       = r_pos3;
  assign bus.rotor_data = r_rotor_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_letter = r_out_letter;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Table-driven bench for rotor_step_ctrl with a result scoreboard and hand-written reset/timeout sequences.
module tb_rotor_step_ctrl;
  import enigma_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rotor_step_ctrl_if bus();

  rotor_step_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  letter_t sb_q[$];

  typedef struct {
    bit      do_load;
    letter_t l1, l2, l3;
    letter_t letter;
    letter_t result;
    int      dly;
    int      stall;
    letter_t e1, e2, e3;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(bit ld, int l1, int l2, int l3, int letter, int result,
                              int dly, int stall, int e1, int e2, int e3);
    vec_t v;
    v.do_load = ld;
    v.l1 = 5'(l1); v.l2 = 5'(l2); v.l3 = 5'(l3);
    v.letter = 5'(letter); v.result = 5'(result);
    v.dly = dly; v.stall = stall;
    v.e1 = 5'(e1); v.e2 = 5'(e2); v.e3 = 5'(e3);
    return v;
  endfunction

  function automatic letter_t sanit(letter_t v);
    return (v >= 5'd26) ? 5'd0 : v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pos(string tag, letter_t e1, letter_t e2, letter_t e3);
    chk({tag, "_pos1"}, int'(bus.pos1), int'(e1));
    chk({tag, "_pos2"}, int'(bus.pos2), int'(e2));
    chk({tag, "_pos3"}, int'(bus.pos3), int'(e3));
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_load(letter_t l1, letter_t l2, letter_t l3);
    bus.load = 1'b1;
    bus.load_pos1 = l1; bus.load_pos2 = l2; bus.load_pos3 = l3;
    bus.in_valid = 1'b1;
    bus.in_letter = 5'd3;
    #1;
    chk("load_blocks_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    bus.load = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk_pos("load", sanit(l1), sanit(l2), sanit(l3));
    chk("load_stays_idle", int'(bus.in_ready), 1);
  endtask

  // dly: WAIT cycle in which done is raised (0 = never). exp_lat: cycles from accept to out_valid.
  task automatic do_letter(letter_t letter, letter_t result, int dly, int stall,
                           letter_t exp_out, int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_letter = letter;
    sb_q.push_back(exp_out);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    if (letter < 5'd26) begin
      chk("busy_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      lat++;
      bus.rotor_done = 1'b1;
      bus.rotor_result = 5'd13;
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        lat++;
        if (k == 1) chk("rotor_data", int'(bus.rotor_data), int'(letter));
        bus.rotor_done = (k == dly);
        bus.rotor_result = result;
      end
      @(negedge clk);
      lat++;
      bus.rotor_done = 1'b0;
    end
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      lat++;
      n++;
    end
    chk("out_valid_seen", int'(bus.out_valid), 1);
    chk("latency", lat, exp_lat);
    for (int s = 0; s < stall; s++) begin
      chk("stall_out_letter", int'(bus.out_letter), int'(exp_out));
      chk("stall_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    chk("stall_out_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    if (bus.out_valid && sb_q.size() > 0) begin
      letter_t e;
      e = sb_q.pop_front();
      chk("out_letter", int'(bus.out_letter), int'(e));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    letter_t ex;
    vecs[0] = mk(1,  0,  0,  0,  0,  7,  2, 3,  1, 0,  0);
    vecs[1] = mk(1, 16,  0,  0,  4,  9,  1, 0, 17, 1,  0);
    vecs[2] = mk(1, 16,  3,  0,  1,  2,  1, 0, 17, 4,  0);
    vecs[3] = mk(0,  0,  0,  0,  2,  3,  3, 1, 18, 5,  1);
    vecs[4] = mk(1, 25,  7,  2, 25,  0,  1, 0,  0, 7,  2);
    vecs[5] = mk(0,  0,  0,  0, 27,  0,  0, 2,  0, 7,  2);
    vecs[6] = mk(1, 30, 26, 31,  5, 11,  1, 5,  1, 0,  0);
    vecs[7] = mk(1, 16,  4, 25, 12, 20,  2, 0, 17, 5,  0);
    vecs[8] = mk(0,  0,  0,  0, 31,  0,  0, 0, 17, 5,  0);

    rst = 1'b1;
    bus.load = 1'b0;
    bus.load_pos1 = 5'd0; bus.load_pos2 = 5'd0; bus.load_pos3 = 5'd0;
    bus.in_valid = 1'b0;
    bus.in_letter = 5'd0;
    bus.rotor_result = 5'd0;
    bus.rotor_done = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_pos("reset", 5'd0, 5'd0, 5'd0);
    chk("reset_rotor_data", int'(bus.rotor_data), 0);
    chk("reset_out_letter", int'(bus.out_letter), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].do_load) do_load(vecs[i].l1, vecs[i].l2, vecs[i].l3);
      ex = (vecs[i].letter >= 5'd26) ? vecs[i].letter : vecs[i].result;
      do_letter(vecs[i].letter, vecs[i].result, vecs[i].dly, vecs[i].stall, ex,
                (vecs[i].letter >= 5'd26) ? 1 : 3 + vecs[i].dly);
      chk_pos($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3);
    end

    // Asynchronous reset in the middle of WAIT drops the letter.
    do_load(5'd10, 5'd10, 5'd10);
    bus.in_valid = 1'b1;
    bus.in_letter = 5'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_rotor_data", int'(bus.rotor_data), 3);
    #2 rst = 1'b1;
    #1;
    chk_pos("async_reset", 5'd0, 5'd0, 5'd0);
    chk("async_reset_out_valid", int'(bus.out_valid), 0);
    chk("async_reset_in_ready", int'(bus.in_ready), 1);
    chk("async_reset_rotor_data", int'(bus.rotor_data), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rotor_done = 1'b1;
    bus.rotor_result = 5'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_no_output", int'(bus.out_valid), 0);
    end
    bus.rotor_done = 1'b0;

`ifdef ROTOR_TIMEOUT_EN
    do_load(5'd2, 5'd0, 5'd0);
    do_letter(5'd6, 5'd0, 0, 1, LETTER_INVALID, 3 + 15);
    chk_pos("timeout", 5'd3, 5'd0, 5'd0);
`else
    do_load(5'd2, 5'd0, 5'd0);
    do_letter(5'd6, 5'd21, 25, 1, 5'd21, 3 + 25);
    chk_pos("long_wait", 5'd3, 5'd0, 5'd0);
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
